// File: rtl/rf_trace_checker_pkg.sv
// Shared types for the register-file trace checker: write-port word/struct,
// buffered trace record, checker state encoding and the default end-of-run PC.
package rf_trace_checker_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic       wen;
        logic [4:0] addr;
        word_t      wdata;
    } rf_w_t;

    typedef struct packed {
        word_t      pc;
        logic [4:0] addr;
        word_t      data;
    } trace_rec_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        ERROR = 2'd1,
        DONE  = 2'd2
    } chk_state_t;

    localparam word_t DEFAULT_END_PC = 32'hbfc0_0100;

    function automatic logic rec_match(input trace_rec_t a, input trace_rec_t b);
        return (a.pc == b.pc) && (a.addr == b.addr) && (a.data == b.data);
    endfunction

endpackage

// File: rtl/rf_trace_checker_trace_fifo.sv
// Committed-write buffer: synchronous push/pop, extra pointer MSB distinguishes
// full from empty so wrap-around needs no separate counter.
module trace_fifo
    import rf_trace_checker_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  trace_rec_t din,
    output trace_rec_t dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    trace_rec_t mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push_ok;
    logic        pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/rf_trace_checker.sv
// Compares register-file writes of the core against a golden trace stream,
// mirrors each write on a registered trace port and latches the first failure.
module rf_trace_checker
    import rf_trace_checker_pkg::*;
#(
    parameter int    FIFO_DEPTH = 8,
    parameter word_t END_PC     = DEFAULT_END_PC
) (
    input  logic       clk,
    input  logic       reset,
    input  rf_w_t      rfw,
    input  word_t      rt_pc,
    input  logic       ref_valid,
    input  word_t      ref_pc,
    input  logic [4:0] ref_addr,
    input  word_t      ref_data,
    output logic       ref_ready,
    output word_t      debug_wb_pc,
    output logic [3:0] debug_wb_rf_wen,
    output logic [4:0] debug_wb_rf_wnum,
    output word_t      debug_wb_rf_wdata,
    output word_t      commit_cnt,
    output logic       mismatch,
    output logic       overflow,
    output logic       done,
    output word_t      err_pc,
    output word_t      err_exp_data,
    output word_t      err_got_data,
    output logic [4:0] err_exp_addr,
    output logic [4:0] err_got_addr,
    output chk_state_t state
);

    trace_rec_t rec_in;
    trace_rec_t ref_rec;
    trace_rec_t head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       running;
    logic       push_req;
    logic       pop;
    logic       cmp_ok;
    logic       ovf;

    assign rec_in  = '{pc: rt_pc, addr: rfw.addr, data: rfw.wdata};
    assign ref_rec = '{pc: ref_pc, addr: ref_addr, data: ref_data};

    // Gating with reset keeps ref_ready low in the reset cycle itself.
    assign running   = (state == RUN) && !reset;
    assign push_req  = running && rfw.wen && (rfw.addr != 5'd0);
    assign pop       = running && !fifo_empty && ref_valid;
    assign ref_ready = pop;
    assign cmp_ok    = rec_match(head, ref_rec);
    assign ovf       = push_req && fifo_full && !pop;

    trace_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .din   (rec_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= RUN;
            debug_wb_pc       <= '0;
            debug_wb_rf_wen   <= '0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
            commit_cnt        <= '0;
            mismatch          <= 1'b0;
            overflow          <= 1'b0;
            done              <= 1'b0;
            err_pc            <= '0;
            err_exp_data      <= '0;
            err_got_data      <= '0;
            err_exp_addr      <= '0;
            err_got_addr      <= '0;
        end else begin
            // Trace port mirrors every write, including $0 and after the run ends.
            if (rfw.wen) begin
                debug_wb_pc       <= rt_pc;
                debug_wb_rf_wen   <= 4'hF;
                debug_wb_rf_wnum  <= rfw.addr;
                debug_wb_rf_wdata <= rfw.wdata;
            end else begin
                debug_wb_pc       <= '0;
                debug_wb_rf_wen   <= '0;
                debug_wb_rf_wnum  <= '0;
                debug_wb_rf_wdata <= '0;
            end

            if (state == RUN) begin
                if (pop && cmp_ok) begin
                    commit_cnt <= commit_cnt + 32'd1;
                    if (head.pc == END_PC) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                if (pop && !cmp_ok) begin
                    state        <= ERROR;
                    mismatch     <= 1'b1;
                    err_pc       <= head.pc;
                    err_exp_data <= ref_data;
                    err_got_data <= head.data;
                    err_exp_addr <= ref_addr;
                    err_got_addr <= head.addr;
                end
                if (ovf) begin
                    state    <= ERROR;
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_trace_checker.sv
// Directed bench for rf_trace_checker: a vector table for the basic
// match/mismatch flow plus hand-written full, overflow, done and reset sequences.
module tb_rf_trace_checker;
    import rf_trace_checker_pkg::*;

    logic       clk;
    logic       reset;
    rf_w_t      rfw;
    word_t      rt_pc;
    logic       ref_valid;
    word_t      ref_pc;
    logic [4:0] ref_addr;
    word_t      ref_data;
    logic       ref_ready;
    word_t      debug_wb_pc;
    logic [3:0] debug_wb_rf_wen;
    logic [4:0] debug_wb_rf_wnum;
    word_t      debug_wb_rf_wdata;
    word_t      commit_cnt;
    logic       mismatch;
    logic       overflow;
    logic       done;
    word_t      err_pc;
    word_t      err_exp_data;
    word_t      err_got_data;
    logic [4:0] err_exp_addr;
    logic [4:0] err_got_addr;
    chk_state_t state;

    int n_vec;
    int n_fail;

    rf_trace_checker #(.FIFO_DEPTH(8), .END_PC(32'hbfc0_0100)) dut (
        .clk               (clk),
        .reset             (reset),
        .rfw               (rfw),
        .rt_pc             (rt_pc),
        .ref_valid         (ref_valid),
        .ref_pc            (ref_pc),
        .ref_addr          (ref_addr),
        .ref_data          (ref_data),
        .ref_ready         (ref_ready),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .commit_cnt        (commit_cnt),
        .mismatch          (mismatch),
        .overflow          (overflow),
        .done              (done),
        .err_pc            (err_pc),
        .err_exp_data      (err_exp_data),
        .err_got_data      (err_got_data),
        .err_exp_addr      (err_exp_addr),
        .err_got_addr      (err_got_addr),
        .state             (state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] a, input word_t d, input word_t pc,
                         input logic rv, input word_t rpc, input logic [4:0] ra, input word_t rd);
        rfw       = '{wen: w, addr: a, wdata: d};
        rt_pc     = pc;
        ref_valid = rv;
        ref_pc    = rpc;
        ref_addr  = ra;
        ref_data  = rd;
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, '0, '0, 1'b0, '0, 5'd0, '0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One clock: drive inputs, check combinational ref_ready, then the trace port after the edge.
    task automatic cycle(input string tag, input logic w, input logic [4:0] a, input word_t d,
                         input word_t pc, input logic rv, input word_t rpc, input logic [4:0] ra,
                         input word_t rd, input logic exp_ready);
        drive(w, a, d, pc, rv, rpc, ra, rd);
        #1;
        chk({tag, "_ready"}, {31'd0, ref_ready}, {31'd0, exp_ready});
        @(posedge clk);
        #1;
        chk({tag, "_trace_pc"}, debug_wb_pc, w ? pc : 32'd0);
        chk({tag, "_trace_wen_wnum"}, {23'd0, debug_wb_rf_wen, debug_wb_rf_wnum},
            {23'd0, (w ? 4'hF : 4'h0), (w ? a : 5'd0)});
        chk({tag, "_trace_wdata"}, debug_wb_rf_wdata, w ? d : 32'd0);
    endtask

    task automatic chk_status(input string tag, input word_t exp_cnt, input logic [2:0] exp_flags,
                              input chk_state_t exp_state);
        chk({tag, "_cnt"}, commit_cnt, exp_cnt);
        chk({tag, "_flags"}, {29'd0, mismatch, overflow, done}, {29'd0, exp_flags});
        chk({tag, "_state"}, {30'd0, state}, {30'd0, exp_state});
    endtask

    typedef struct {
        logic       wen;
        logic [4:0] addr;
        word_t      wdata;
        word_t      pc;
        logic       rv;
        word_t      rpc;
        logic [4:0] raddr;
        word_t      rdata;
        logic       exp_ready;
        word_t      exp_cnt;
        logic [2:0] exp_flags;   // {mismatch, overflow, done}
        chk_state_t exp_state;
    } vec_t;

    vec_t vecs [11];

    initial begin
        n_vec  = 0;
        n_fail = 0;
        reset  = 1'b1;

        vecs[0]  = '{1'b1, 5'd1, 32'h11, 32'hbfc00000, 1'b1, 32'hbfc00000, 5'd1, 32'h11, 1'b0, 32'd0, 3'b000, RUN};
        vecs[1]  = '{1'b1, 5'd2, 32'h22, 32'hbfc00004, 1'b1, 32'hbfc00000, 5'd1, 32'h11, 1'b1, 32'd1, 3'b000, RUN};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,  32'h0,        1'b1, 32'hbfc00004, 5'd2, 32'h22, 1'b1, 32'd2, 3'b000, RUN};
        vecs[3]  = '{1'b1, 5'd0, 32'h55, 32'hbfc00008, 1'b1, 32'hbfc00008, 5'd0, 32'h55, 1'b0, 32'd2, 3'b000, RUN};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,  32'h0,        1'b1, 32'hbfc00008, 5'd0, 32'h55, 1'b0, 32'd2, 3'b000, RUN};
        vecs[5]  = '{1'b1, 5'd3, 32'h33, 32'hbfc0000c, 1'b0, 32'h0,        5'd0, 32'h0,  1'b0, 32'd2, 3'b000, RUN};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,  32'h0,        1'b0, 32'hbfc0000c, 5'd3, 32'h33, 1'b0, 32'd2, 3'b000, RUN};
        vecs[7]  = '{1'b1, 5'd2, 32'h22, 32'hbfc00004, 1'b1, 32'hbfc0000c, 5'd3, 32'h33, 1'b1, 32'd3, 3'b000, RUN};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,  32'h0,        1'b1, 32'hbfc00004, 5'd2, 32'h23, 1'b1, 32'd3, 3'b100, ERROR};
        vecs[9]  = '{1'b1, 5'd4, 32'h44, 32'hbfc00010, 1'b1, 32'hbfc00010, 5'd4, 32'h44, 1'b0, 32'd3, 3'b100, ERROR};
        vecs[10] = '{1'b0, 5'd0, 32'h0,  32'h0,        1'b1, 32'hbfc00010, 5'd4, 32'h44, 1'b0, 32'd3, 3'b100, ERROR};

        // reset state
        do_reset();
        chk_status("reset", 32'd0, 3'b000, RUN);
        chk("reset_ready", {31'd0, ref_ready}, 32'd0);
        chk("reset_trace_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
        chk("reset_err_pc", err_pc, 32'd0);

        // table: match, $0/idle, valid gating, mismatch, frozen ERROR
        for (int i = 0; i < 11; i++) begin
            cycle($sformatf("v%0d", i), vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].pc,
                  vecs[i].rv, vecs[i].rpc, vecs[i].raddr, vecs[i].rdata, vecs[i].exp_ready);
            chk_status($sformatf("v%0d", i), vecs[i].exp_cnt, vecs[i].exp_flags, vecs[i].exp_state);
        end
        chk("mis_err_pc", err_pc, 32'hbfc00004);
        chk("mis_err_exp_data", err_exp_data, 32'h23);
        chk("mis_err_got_data", err_got_data, 32'h22);
        chk("mis_err_addrs", {22'd0, err_exp_addr, err_got_addr}, {22'd0, 5'd2, 5'd2});

        // full FIFO with simultaneous push and pop, then drain
        do_reset();
        for (int i = 0; i < 8; i++)
            cycle($sformatf("fill%0d", i), 1'b1, 5'(i + 1), 32'h100 + 32'(i), 32'hbfc01000 + 32'(4 * i),
                  1'b0, '0, 5'd0, '0, 1'b0);
        chk_status("fill", 32'd0, 3'b000, RUN);
        cycle("fullpp", 1'b1, 5'd9, 32'h108, 32'hbfc01020, 1'b1, 32'hbfc01000, 5'd1, 32'h100, 1'b1);
        chk_status("fullpp", 32'd1, 3'b000, RUN);
        for (int i = 1; i < 9; i++) begin
            cycle($sformatf("drain%0d", i), 1'b0, 5'd0, '0, '0, 1'b1, 32'hbfc01000 + 32'(4 * i),
                  5'(i + 1), 32'h100 + 32'(i), 1'b1);
            chk($sformatf("drain%0d_cnt", i), commit_cnt, 32'(i + 1));
        end
        cycle("drained", 1'b0, 5'd0, '0, '0, 1'b1, 32'hbfc01024, 5'd10, 32'h109, 1'b0);
        chk_status("drained", 32'd9, 3'b000, RUN);

        // overflow on the ninth write with no golden records
        do_reset();
        for (int i = 0; i < 8; i++)
            cycle($sformatf("ovf%0d", i), 1'b1, 5'(i + 1), 32'h200 + 32'(i), 32'hbfc03000 + 32'(4 * i),
                  1'b0, '0, 5'd0, '0, 1'b0);
        chk_status("ovf8", 32'd0, 3'b000, RUN);
        cycle("ovf9", 1'b1, 5'd9, 32'h208, 32'hbfc03020, 1'b0, '0, 5'd0, '0, 1'b0);
        chk_status("ovf9", 32'd0, 3'b010, ERROR);
        chk("ovf_err_data", err_got_data | err_exp_data | err_pc, 32'd0);
        cycle("ovf_after", 1'b0, 5'd0, '0, '0, 1'b1, 32'hbfc03000, 5'd1, 32'h200, 1'b0);

        // matched write at END_PC finishes the run
        do_reset();
        cycle("end_w", 1'b1, 5'd5, 32'h5a, 32'hbfc00100, 1'b0, '0, 5'd0, '0, 1'b0);
        cycle("end_c", 1'b0, 5'd0, '0, '0, 1'b1, 32'hbfc00100, 5'd5, 32'h5a, 1'b1);
        chk_status("end", 32'd1, 3'b001, DONE);
        cycle("done_w", 1'b1, 5'd6, 32'h66, 32'hbfc00104, 1'b1, 32'hbfc00104, 5'd6, 32'h66, 1'b0);
        cycle("done_c", 1'b0, 5'd0, '0, '0, 1'b1, 32'hbfc00104, 5'd6, 32'h66, 1'b0);
        chk_status("done", 32'd1, 3'b001, DONE);

        // reset while three records are buffered and a compare is pending
        do_reset();
        cycle("rb1", 1'b1, 5'd1, 32'h71, 32'hbfc04000, 1'b0, '0, 5'd0, '0, 1'b0);
        cycle("rb2", 1'b1, 5'd2, 32'h72, 32'hbfc04004, 1'b1, 32'hbfc04000, 5'd1, 32'h71, 1'b1);
        cycle("rb3", 1'b1, 5'd3, 32'h73, 32'hbfc04008, 1'b0, '0, 5'd0, '0, 1'b0);
        cycle("rb4", 1'b1, 5'd4, 32'h74, 32'hbfc0400c, 1'b0, '0, 5'd0, '0, 1'b0);
        chk_status("rb", 32'd1, 3'b000, RUN);
        drive(1'b0, 5'd0, '0, '0, 1'b1, 32'hbfc04004, 5'd2, 32'h72);
        reset = 1'b1;
        #1;
        chk("rst_cycle_ready", {31'd0, ref_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_status("post_rst", 32'd0, 3'b000, RUN);
        cycle("post_rst_empty", 1'b0, 5'd0, '0, '0, 1'b1, 32'hbfc04004, 5'd2, 32'h72, 1'b0);
        cycle("post_rst_w", 1'b1, 5'd6, 32'h66, 32'hbfc02000, 1'b1, 32'hbfc02000, 5'd6, 32'h66, 1'b0);
        cycle("post_rst_c", 1'b0, 5'd0, '0, '0, 1'b1, 32'hbfc02000, 5'd6, 32'h66, 1'b1);
        chk_status("post_rst_c", 32'd1, 3'b000, RUN);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_trace_checker.md
RF_TRACE_CHECKER -- requirements
Module: rf_trace_checker

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, capacity of the committed-write buffer (power of two, >=2).
REQ-002 Parameter END_PC, default 32'hbfc0_0100, PC whose matched write ends the run.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rfw  in  rf_w_t  one register-file write per cycle from the serializing write queue (wen, addr[4:0], wdata[31:0]).
REQ-006 rt_pc  in  32  PC of the instruction that produced rfw.
REQ-007 ref_valid  in  1  golden-trace record available.
REQ-008 ref_pc / ref_addr / ref_data  in  32 / 5 / 32  golden record fields.
REQ-009 ref_ready  out  1  golden record consumed this cycle.
REQ-010 debug_wb_pc / debug_wb_rf_wen / debug_wb_rf_wnum / debug_wb_rf_wdata  out  32 / 4 / 5 / 32  registered commit trace port.
REQ-011 commit_cnt  out  32  count of compared-and-matched writes.
REQ-012 mismatch / overflow / done  out  1 each  sticky status flags.
REQ-013 err_pc, err_exp_data, err_got_data  out  32 each; err_exp_addr, err_got_addr  out  5 each  capture of the first failing comparison.

Function
REQ-014 A record is pushed when rfw.wen=1 and rfw.addr!=0; writes to $0 and wen=0 cycles are never buffered or compared.
REQ-015 Trace port: one cycle after any cycle with rfw.wen=1, debug_wb_pc=rt_pc, debug_wb_rf_wen=4'hF, wnum=addr, wdata=wdata; otherwise debug_wb_rf_wen=0 and other trace fields 0.
REQ-016 States: RUN, ERROR, DONE; reset enters RUN.
REQ-017 In RUN, ref_ready=1 iff FIFO non-empty and ref_valid=1 (combinational); that cycle pops one record and compares pc, addr, data against ref_*.
REQ-018 All three fields equal: commit_cnt increments by 1 (wraps at 2^32); if record pc==END_PC, next state DONE and done=1.
REQ-019 Any field differs: next state ERROR, mismatch=1, err_* capture the popped record and the golden record; commit_cnt not incremented.
REQ-020 Push with FIFO full and no pop in the same cycle: record dropped, overflow=1, next state ERROR (err_* unchanged, remain 0 if never set).
REQ-021 Push and pop in the same cycle when full: both proceed, no overflow.
REQ-022 Push when empty: record is not comparable until the following cycle (one-cycle minimum latency rfw->ref_ready).
REQ-023 In ERROR and DONE: ref_ready=0, no pushes, no pops, commit_cnt and err_* frozen; trace port continues per REQ-015; state held until reset.
REQ-024 Status flags and err_* are set only on the first terminating event; simultaneous mismatch and overflow set both flags.
REQ-025 FIFO pointers are log2(FIFO_DEPTH)+1 bits; full/empty from MSB comparison; wrap-around is transparent.

Reset
REQ-026 reset=1 at any edge, including mid-comparison: state RUN, FIFO empty, all outputs and captures 0, ref_ready=0 in the reset cycle.
REQ-027 The first push is accepted on the first edge with reset=0.

Structure
REQ-028 rf_w_t and word_t come from mips.svh; new typedefs trace_rec_t {pc, addr, data} and chk_state_t, plus default END_PC, belong in the shared package.
REQ-029 The buffer is the sub-module trace_fifo (trace_rec_t entries, synchronous push/pop, full/empty outputs); the FSM, compare, and trace port stay in rf_trace_checker.

Verification
REQ-030 Writes (pc 0xbfc00000, $1, 0x11), (0xbfc00004, $2, 0x22) with matching golden records -> two ref_ready pulses, commit_cnt=2, no flags.
REQ-031 Write to $0 plus wen=0 cycles -> no push, ref_ready stays 0, trace port shows $0 write with wen 4'hF.
REQ-032 Golden data 0x23 vs committed 0x22 at 0xbfc00004 -> mismatch=1, err_exp_data=0x23, err_got_data=0x22, state ERROR, ref_ready 0 afterwards.
REQ-033 ref_valid=0 while 9 consecutive writes arrive (FIFO_DEPTH=8) -> overflow=1 on the 9th, state ERROR.
REQ-034 Matched write at pc 0xbfc00100 -> done=1, commit_cnt frozen, later writes ignored.
REQ-035 reset pulsed with 3 records buffered -> FIFO empty, flags 0, commit_cnt=0, normal matching resumes next cycle.
